regfile_read_port: RTL and testbench

- Read-side controller for the bit-cell register file.
- Accepts a two-operand read request over a valid/ready handshake and decodes the register IDs into one-hot ReadEnable1/ReadEnable2 wordlines for the cell array.
- Samples the two shared bitline buses and returns both operands over a second valid/ready handshake.
- Handles R0 (reads as zero), write-bypass, and output back-pressure.

---
 rtl/regfile_read_port_if.sv | 27 ++
 rtl/regfile_read_port.sv | 136 +++++++++++++
 tb/tb_regfile_read_port.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_port_if.sv
// Request/response handshake bundle between the read-port controller and
// its client: a two-operand read request in, two operands back out.
interface regfile_read_port_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] src_reg1;
  logic [ADDR_W-1:0] src_reg2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;

  // Client side: issues requests and consumes operands.
  modport master (
    output req_valid, src_reg1, src_reg2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );

  // Controller side.
  modport slave (
    input  req_valid, src_reg1, src_reg2, rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_read_port.sv
// Read-side controller for the bit-cell register file. Decodes latched
// register IDs into one-hot wordlines for one cycle (DRIVE), samples the
// bitlines at the end of that cycle and holds the operands in RESP until
// the consumer takes them. R0 and out-of-range IDs read as zero; a write to
// the same register during DRIVE is forwarded instead of the stale bitline.
module regfile_read_port #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  regfile_read_port_if.slave  bus,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_reg,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] read_en1,
  output logic [NUM_REGS-1:0] read_en2,
  input  logic [DATA_W-1:0]   bitline1,
  input  logic [DATA_W-1:0]   bitline2
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   id1_q, id1_d, id2_q, id2_d;
  logic [NUM_REGS-1:0] read_en1_q, read_en1_d, read_en2_q, read_en2_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data1_q, rsp_data1_d, rsp_data2_q, rsp_data2_d;
  logic                req_ready;
  logic                accept;

  // Row 0 is hard-wired zero and rows past NUM_REGS do not exist, so
  // neither ever gets a wordline.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] id);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (id == ADDR_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // A register with no wordline reads as zero; otherwise a same-cycle write
  // wins over the bitline, which still shows the pre-write cell value.
  function automatic logic [DATA_W-1:0] operand(
    input logic [ADDR_W-1:0] id,
    input logic [DATA_W-1:0] bl,
    input logic              we,
    input logic [ADDR_W-1:0] wreg,
    input logic [DATA_W-1:0] wdata
  );
    if (decode(id) == '0)         return '0;
    if (we && (wreg == id))       return wdata;
    return bl;
  endfunction

  // Ready in IDLE, or in RESP when the held response is leaving this edge.
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  // Next-state and datapath for the IDLE -> DRIVE -> RESP sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    id1_d       = id1_q;
    id2_d       = id2_q;
    read_en1_d  = '0;
    read_en2_d  = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;

    case (state_q)
      IDLE: ;
      DRIVE: begin
        rsp_data1_d = operand(id1_q, bitline1, wr_en, wr_reg, wr_data);
        rsp_data2_d = operand(id2_q, bitline2, wr_en, wr_reg, wr_data);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance (from IDLE or back-to-back from RESP) overrides the above.
    if (accept) begin
      id1_d      = bus.src_reg1;
      id2_d      = bus.src_reg2;
      read_en1_d = decode(bus.src_reg1);
      read_en2_d = decode(bus.src_reg2);
      state_d    = DRIVE;
    end
  end

  // State registers; reset drops wordlines and the response immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id1_q       <= '0;
      id2_q       <= '0;
      read_en1_q  <= '0;
      read_en2_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      id1_q       <= id1_d;
      id2_q       <= id2_d;
      read_en1_q  <= read_en1_d;
      read_en2_q  <= read_en2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
    end
  end

  assign read_en1      = read_en1_q;
  assign read_en2      = read_en2_q;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port with 12 rows (so IDs 12..15 are out of range).
// The cell array is a plain memory; bitlines OR together enabled rows and
// carry random noise when no row is enabled, so operands that must read as
// zero cannot pass by accident.
module tb_regfile_read_port;
  localparam int NREGS = 12;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [NREGS-1:0] read_en1, read_en2;
  logic [DW-1:0] bitline1, bitline2, noise1, noise2;
  logic [DW-1:0] mem [NREGS];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_read_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_read_port #(.NUM_REGS(NREGS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .read_en1 (read_en1),
    .read_en2 (read_en2),
    .bitline1 (bitline1),
    .bitline2 (bitline2)
  );

  // Cell array: write updates the cell at the clock edge.
  always @(posedge clk) begin
    if (wr_en && int'(wr_reg) < NREGS) mem[wr_reg] <= wr_data;
  end

  // Bitline buses seen by the controller.
  always_comb begin
    bitline1 = '0;
    bitline2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (read_en1[i]) bitline1 = bitline1 | mem[i];
      if (read_en2[i]) bitline2 = bitline2 | mem[i];
    end
    if (read_en1 == '0) bitline1 = noise1;
    if (read_en2 == '0) bitline2 = noise2;
  end

  // Reference: wordline a request should raise.
  function automatic logic [NREGS-1:0] exp_wl(input int id);
    logic [NREGS-1:0] one;
    one = NREGS'(1);
    return (id > 0 && id < NREGS) ? (one << id) : '0;
  endfunction

  // Reference: operand captured for an ID, given the write inputs present
  // during the DRIVE cycle and the array contents before that write.
  function automatic logic [DW-1:0] exp_op(input int id);
    if (id == 0 || id >= NREGS) return '0;
    if (wr_en && int'(wr_reg) == id) return wr_data;
    return mem[id];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    noise1 = DW'($urandom);
    noise2 = DW'($urandom);
  endtask

  // Present a request and return one step after the accepting edge (DRIVE).
  task automatic issue(input int a, input int b);
    bus.src_reg1  = AW'(a);
    bus.src_reg2  = AW'(b);
    bus.req_valid = 1'b1;
    #1;
    for (int n = 0; n < 20 && !bus.req_ready; n++) tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready=%b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic preload();
    for (int r = 0; r < NREGS; r++) begin
      wr_en   = 1'b1;
      wr_reg  = AW'(r);
      wr_data = (r == 3) ? 16'h1234 : (r == 7) ? 16'hBEEF :
                (r == 5) ? 16'h0000 : DW'($urandom);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (read_en1 !== '0) begin errors++; $display("FAIL rst_wl1: got %h want 0", read_en1); end
    checks++; if (read_en2 !== '0) begin errors++; $display("FAIL rst_wl2: got %h want 0", read_en2); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data1 !== '0) begin errors++; $display("FAIL rst_data1: got %h want 0", bus.rsp_data1); end
    checks++; if (bus.rsp_data2 !== '0) begin errors++; $display("FAIL rst_data2: got %h want 0", bus.rsp_data2); end
    #14 rst = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] e1, e2;
    bus.rsp_ready = 1'b1;
    issue(3, 7);
    checks++; if (read_en1 !== 12'h008) begin errors++; $display("FAIL basic_wl1: got %h want 008", read_en1); end
    checks++; if (read_en2 !== 12'h080) begin errors++; $display("FAIL basic_wl2: got %h want 080", read_en2); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL basic_drive_ready: got %b want 0", bus.req_ready); end
    e1 = exp_op(3);
    e2 = exp_op(7);
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_data1 !== e1 || e1 !== 16'h1234) begin errors++; $display("FAIL basic_data1: got %h want 1234", bus.rsp_data1); end
    checks++; if (bus.rsp_data2 !== e2 || e2 !== 16'hBEEF) begin errors++; $display("FAIL basic_data2: got %h want beef", bus.rsp_data2); end
    checks++; if ((read_en1 | read_en2) !== '0) begin errors++; $display("FAIL basic_resp_wl: got %h/%h want 0", read_en1, read_en2); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_r0_bypass();
    logic [DW-1:0] e1, e2;
    bus.rsp_ready = 1'b1;
    // Forward to operand 2; R0 stays zero.
    issue(0, 5);
    wr_en = 1'b1; wr_reg = 4'd5; wr_data = 16'hA5A5;
    checks++; if (read_en1 !== '0) begin errors++; $display("FAIL r0_wl1: got %h want 0", read_en1); end
    checks++; if (bitline2 !== 16'h0000) begin errors++; $display("FAIL byp_bitline2: got %h want 0000", bitline2); end
    e1 = exp_op(0);
    e2 = exp_op(5);
    tick();
    wr_en = 1'b0;
    checks++; if (bus.rsp_data1 !== e1) begin errors++; $display("FAIL r0_data1: got %h want %h", bus.rsp_data1, e1); end
    checks++; if (bus.rsp_data2 !== e2 || e2 !== 16'hA5A5) begin errors++; $display("FAIL byp_data2: got %h want a5a5", bus.rsp_data2); end
    tick();
    // A write to R0 must not leak into operand 1.
    issue(0, 5);
    wr_en = 1'b1; wr_reg = 4'd0; wr_data = 16'hFFFF;
    e1 = exp_op(0);
    e2 = exp_op(5);
    tick();
    wr_en = 1'b0;
    checks++; if (bus.rsp_data1 !== e1) begin errors++; $display("FAIL r0w_data1: got %h want %h", bus.rsp_data1, e1); end
    checks++; if (bus.rsp_data2 !== e2) begin errors++; $display("FAIL r0w_data2: got %h want %h", bus.rsp_data2, e2); end
    tick();
    // Both operands forward from the same write.
    issue(6, 6);
    wr_en = 1'b1; wr_reg = 4'd6; wr_data = 16'h5AC3;
    e1 = exp_op(6);
    tick();
    wr_en = 1'b0;
    checks++; if (bus.rsp_data1 !== e1 || bus.rsp_data2 !== e1) begin
      errors++; $display("FAIL byp_both: got %h/%h want %h", bus.rsp_data1, bus.rsp_data2, e1);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] e2;
    bus.rsp_ready = 1'b1;
    issue(13, 2);
    checks++; if (read_en1 !== '0) begin errors++; $display("FAIL oor_wl1: got %h want 0", read_en1); end
    checks++; if (read_en2 !== exp_wl(2)) begin errors++; $display("FAIL oor_wl2: got %h want %h", read_en2, exp_wl(2)); end
    e2 = exp_op(2);
    tick();
    checks++; if (bus.rsp_data1 !== '0) begin errors++; $display("FAIL oor_data1: got %h want 0", bus.rsp_data1); end
    checks++; if (bus.rsp_data2 !== e2) begin errors++; $display("FAIL oor_data2: got %h want %h", bus.rsp_data2, e2); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e1, e2;
    bus.rsp_ready = 1'b0;
    issue(8, 1);
    e1 = exp_op(8);
    e2 = exp_op(1);
    tick();
    bus.src_reg1 = 4'd9; bus.src_reg2 = 4'd10; bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      wr_en = 1'b1; wr_reg = 4'd8; wr_data = DW'($urandom);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== e1 || bus.rsp_data2 !== e2 ||
          bus.req_ready !== 1'b0 || (read_en1 | read_en2) !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b d=%h/%h ready=%b wl=%h/%h want 1 %h/%h 0 0/0",
                 c, bus.rsp_valid, bus.rsp_data1, bus.rsp_data2, bus.req_ready,
                 read_en1, read_en2, e1, e2);
      end
      tick();
    end
    wr_en = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (read_en1 !== exp_wl(9) || read_en2 !== exp_wl(10) || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_next_drive: wl=%h/%h valid=%b want %h/%h 0",
                         read_en1, read_en2, bus.rsp_valid, exp_wl(9), exp_wl(10));
    end
    e1 = exp_op(9);
    e2 = exp_op(10);
    tick();
    checks++; if (bus.rsp_data1 !== e1 || bus.rsp_data2 !== e2) begin
      errors++; $display("FAIL bp_next_data: got %h/%h want %h/%h", bus.rsp_data1, bus.rsp_data2, e1, e2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int a, b;
    logic [DW-1:0] e1, e2;
    bus.rsp_ready = 1'b1;
    a = $urandom_range(15, 0);
    b = $urandom_range(15, 0);
    issue(a, b);
    for (int k = 0; k < 8; k++) begin
      // DRIVE cycle, possibly with a write that must be forwarded.
      wr_en   = 1'($urandom_range(1, 0));
      wr_reg  = AW'($urandom_range(NREGS - 1, 1));
      wr_data = DW'($urandom);
      checks++;
      if (read_en1 !== exp_wl(a) || read_en2 !== exp_wl(b) || bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_drive[%0d]: wl=%h/%h valid=%b want %h/%h 0",
                 k, read_en1, read_en2, bus.rsp_valid, exp_wl(a), exp_wl(b));
      end
      e1 = exp_op(a);
      e2 = exp_op(b);
      if (k < 7) begin
        a = $urandom_range(15, 0);
        b = $urandom_range(15, 0);
        bus.src_reg1 = AW'(a); bus.src_reg2 = AW'(b); bus.req_valid = 1'b1;
      end
      tick();
      // RESP cycle; also the accepting cycle of the next request.
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== e1 || bus.rsp_data2 !== e2 ||
          bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: valid=%b d=%h/%h ready=%b want 1 %h/%h 1",
                 k, bus.rsp_valid, bus.rsp_data1, bus.rsp_data2, bus.req_ready, e1, e2);
      end
      wr_en   = 1'($urandom_range(1, 0));
      wr_reg  = AW'($urandom_range(NREGS - 1, 1));
      wr_data = DW'($urandom);
      tick();
      bus.req_valid = 1'b0;
    end
    wr_en = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_mid_reset();
    bus.rsp_ready = 1'b0;
    issue(4, 9);
    checks++; if (read_en1 !== exp_wl(4)) begin errors++; $display("FAIL mr_drive_wl1: got %h want %h", read_en1, exp_wl(4)); end
    #1 rst = 1'b1;
    #1;
    checks++; if ((read_en1 | read_en2) !== '0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mr_async: wl=%h/%h valid=%b want 0/0 0", read_en1, read_en2, bus.rsp_valid);
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_held_valid: got %b want 0", bus.rsp_valid); end
    #2 rst = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_data1 !== '0 || bus.rsp_data2 !== '0) begin
      errors++; $display("FAIL mr_data: got %h/%h want 0/0", bus.rsp_data1, bus.rsp_data2);
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    noise1 = 16'h3C3C; noise2 = 16'hC3C3;
    bus.req_valid = 1'b0; bus.src_reg1 = '0; bus.src_reg2 = '0; bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    preload();
    test_basic();
    test_r0_bypass();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
